msp430_double_op_ctrl: RTL and testbench
========================================

# msp430_double_op_ctrl

Control FSM that sequences the MSP430x2xx format-I (double-operand) datapath: instruction fetch, decode, optional immediate-word fetch, ALU execute and register/flag writeback. It sits between instruction memory and the register file/ALU, drives the 5-bit `Fsm` state observed at the core top level, and generates `PC_inc`, `Wr_en`, `Src_reg` and `Dst_reg`. Supported addressing is register→register and immediate (`#N`, As=11 with src=R0) → register; everything else is trapped as illegal.

## Interface
- No parameters; widths fixed by the MSP430 ISA.
- `Clk` in 1: single clock, rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `Load_en` in 1: run enable; high starts/continues execution, low stops at the next instruction boundary.
- `Mem_data` in 16: instruction/extension word from memory at current PC.
- `Mem_ready` in 1: `Mem_data` valid this cycle.
- `Fetch_req` out 1: memory read request at PC.
- `PC_inc` out 1: one-cycle pulse, PC += 2.
- `Instr` out 16: latched instruction register (IR).
- `Imm` out 16: latched immediate word.
- `Src_sel` out 1: ALU B operand, 0 = register file, 1 = `Imm`.
- `Src_reg` out 4: IR[11:8].
- `Dst_reg` out 4: IR[3:0].
- `Alu_op` out 4: IR[15:12], valid in EXEC.
- `Byte_op` out 1: IR[6].
- `Wr_en` out 1: register-file write of `Dst_reg`.
- `Flags_wr` out 1: status register update from the ALU.
- `Fsm` out 5: current state encoding.
- `Illegal` out 1: one-cycle pulse on a trapped instruction.

## Operation
- States and encoding: IDLE=0, FETCH=1, DECODE=2, IMM=3, EXEC=4, WB=5, ILLEGAL=31.
- IDLE: all strobes low; `Load_en`=1 → FETCH.
- FETCH: `Fetch_req`=1. When `Mem_ready`=1, IR←`Mem_data`, `PC_inc` pulses and the FSM moves to DECODE. Otherwise it stays in FETCH.
- DECODE: the instruction is legal iff all of the following hold:
  - IR[15:12] ≥ 4;
  - Ad (IR[7]) = 0;
  - As (IR[5:4]) = 00, or As = 11 with IR[11:8] = 0;
  - IR[3:0] ≠ 0 (PC destination not supported).
- DECODE transitions: legal and As=11 → IMM; legal and As=00 → EXEC; not legal → ILLEGAL.
- IMM: `Fetch_req`=1. When `Mem_ready`=1, Imm←`Mem_data`, `PC_inc` pulses and the FSM moves to EXEC. Otherwise it stays in IMM.
- EXEC: `Alu_op` and `Src_sel` are presented; `Src_sel`=1 iff As=11. → WB.
- WB:
  - `Wr_en`=1 unless opcode is CMP (9) or BIT (B).
  - `Flags_wr`=1 unless opcode is MOV (4), BIC (C) or BIS (D).
  - Then → FETCH if `Load_en`=1, else → IDLE.
- ILLEGAL: `Illegal`=1 and no writes. → FETCH if `Load_en`=1, else → IDLE. The offending word is skipped because PC has already advanced.
- `Load_en` is sampled only in IDLE, WB and ILLEGAL. Dropping it mid-instruction never aborts that instruction.
- `Src_reg`, `Dst_reg`, `Alu_op` and `Byte_op` are combinational slices of IR, stable from DECODE until the next IR load.

## Timing
- Reset (asynchronous, `Rst_n`=0):
  - `Fsm`=0 (IDLE);
  - `Instr`=0000h and `Imm`=0000h;
  - all 1-bit outputs = 0;
  - `Src_reg`, `Dst_reg` and `Alu_op` = 0.
- Reset asserted mid-instruction takes effect immediately; no write strobe may fire afterward.
- Strobe timing:
  - `Fetch_req` and `PC_inc` are combinational from state and `Mem_ready`.
  - `Wr_en`, `Flags_wr` and `Illegal` are Moore outputs of the state.
  - IR and Imm load on the rising edge that leaves FETCH or IMM.
- Latency with `Mem_ready` held high:
  - register source: 4 cycles (FETCH→DECODE→EXEC→WB);
  - immediate source: 5 cycles;
  - illegal: 3 cycles.
- Each cycle with `Mem_ready`=0 in FETCH or IMM adds 1 cycle. `PC_inc` fires exactly once per accepted word.
- Back-to-back instructions: FETCH immediately follows WB, with no idle cycle.

## Test plan
- Reset, then `Load_en`=1, `Mem_ready`=1, `Mem_data`=5405h (ADD R4,R5) → `Fsm` 1,2,4,5; `Src_reg`=4, `Dst_reg`=5, `Alu_op`=5; `Wr_en`=1 and `Flags_wr`=1 in WB; exactly 1 `PC_inc`.
- `Mem_data`=4036h (MOV #imm,R6), then 00AAh → states 1,2,3,4,5; `Imm`=00AAh; `Src_sel`=1 in EXEC; `Wr_en`=1, `Flags_wr`=0; 2 `PC_inc`.
- CMP R4,R5 (9405h) → WB with `Wr_en`=0 and `Flags_wr`=1. BIS R4,R5 (D405h) → `Wr_en`=1, `Flags_wr`=0.
- 1405h (opcode<4), 5485h (Ad=1) and 5404h-style PC-destination word 5400h → ILLEGAL (`Fsm`=31), one-cycle `Illegal` pulse, no `Wr_en`, then FETCH.
- `Mem_ready` low for 3 cycles in FETCH and then in IMM → `Fsm` holds 1 and 3 respectively, no `PC_inc` while low, total latency 5+6 cycles.
- Drop `Load_en` during EXEC → WB still writes, then IDLE. Assert `Rst_n`=0 during EXEC → `Fsm`=0 asynchronously, `Wr_en` never asserted.

Source files
------------

// File: rtl/msp430_double_op_ctrl.sv
// Control FSM for the MSP430 format-I (double-operand) datapath: fetch, decode,
// optional immediate fetch, execute and writeback, with illegal-form trapping.

package msp430_double_op_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_FETCH   = 5'd1,
    ST_DECODE  = 5'd2,
    ST_IMM     = 5'd3,
    ST_EXEC    = 5'd4,
    ST_WB      = 5'd5,
    ST_ILLEGAL = 5'd31
  } state_e;

  localparam logic [3:0] OP_MIN = 4'h4;
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_BIT = 4'hB;
  localparam logic [3:0] OP_BIC = 4'hC;
  localparam logic [3:0] OP_BIS = 4'hD;

  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IMM = 2'b11;

  // Only Rn->Rm and #N->Rm (As=11 through R0) are implemented; PC as destination is trapped.
  function automatic logic decode_legal(input logic [15:0] ir);
    logic op_ok, ad_ok, as_ok, dst_ok;
    op_ok  = (ir[15:12] >= OP_MIN);
    ad_ok  = (ir[7] == 1'b0);
    as_ok  = (ir[5:4] == AS_REG) || ((ir[5:4] == AS_IMM) && (ir[11:8] == 4'h0));
    dst_ok = (ir[3:0] != 4'h0);
    return op_ok && ad_ok && as_ok && dst_ok;
  endfunction

  function automatic logic is_imm_src(input logic [15:0] ir);
    return ir[5:4] == AS_IMM;
  endfunction

  function automatic logic writes_dst(input logic [3:0] op);
    return (op != OP_CMP) && (op != OP_BIT);
  endfunction

  function automatic logic writes_flags(input logic [3:0] op);
    return (op != OP_MOV) && (op != OP_BIC) && (op != OP_BIS);
  endfunction

endpackage

module msp430_double_op_ctrl
  import msp430_double_op_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Load_en,
  input  logic [15:0] Mem_data,
  input  logic        Mem_ready,
  output logic        Fetch_req,
  output logic        PC_inc,
  output logic [15:0] Instr,
  output logic [15:0] Imm,
  output logic        Src_sel,
  output logic [3:0]  Src_reg,
  output logic [3:0]  Dst_reg,
  output logic [3:0]  Alu_op,
  output logic        Byte_op,
  output logic        Wr_en,
  output logic        Flags_wr,
  output logic [4:0]  Fsm,
  output logic        Illegal
);

  state_e      state_q;
  logic [15:0] instr_q;
  logic [15:0] imm_q;
  logic        src_sel_q;
  logic        wr_en_q;
  logic        flags_wr_q;
  logic        illegal_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= 16'h0000;
      imm_q      <= 16'h0000;
      src_sel_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      flags_wr_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      // NOTE: strobes default low with a non-blocking assignment and are
      // overridden below; the last NBA wins, so each is high for exactly the
      // one state it is set on the way into.
      src_sel_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      flags_wr_q <= 1'b0;
      illegal_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (Load_en) state_q <= ST_FETCH;
        end

        ST_FETCH: begin
          if (Mem_ready) begin
            instr_q <= Mem_data;
            state_q <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (!decode_legal(instr_q)) begin
            illegal_q <= 1'b1;
            state_q   <= ST_ILLEGAL;
          end else if (is_imm_src(instr_q)) begin
            state_q <= ST_IMM;
          end else begin
            state_q <= ST_EXEC;
          end
        end

        ST_IMM: begin
          if (Mem_ready) begin
            imm_q     <= Mem_data;
            src_sel_q <= 1'b1;
            state_q   <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          wr_en_q    <= writes_dst(instr_q[15:12]);
          flags_wr_q <= writes_flags(instr_q[15:12]);
          state_q    <= ST_WB;
        end

        // Run enable is only honoured at instruction boundaries.
        ST_WB, ST_ILLEGAL: begin
          state_q <= Load_en ? ST_FETCH : ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Fetch_req = (state_q == ST_FETCH) || (state_q == ST_IMM);
  assign PC_inc    = Fetch_req && Mem_ready;

  assign Instr    = instr_q;
  assign Imm      = imm_q;
  assign Src_sel  = src_sel_q;
  assign Src_reg  = instr_q[11:8];
  assign Dst_reg  = instr_q[3:0];
  assign Alu_op   = instr_q[15:12];
  assign Byte_op  = instr_q[6];
  assign Wr_en    = wr_en_q;
  assign Flags_wr = flags_wr_q;
  assign Illegal  = illegal_q;
  assign Fsm      = state_q;

endmodule

// File: tb/tb_msp430_double_op_ctrl.sv
// Scoreboard bench for msp430_double_op_ctrl: a memory driver serves a word
// stream, and a monitor checks each completed instruction against a reference model.

module tb_msp430_double_op_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Load_en = 1'b0;
  logic [15:0] Mem_data = 16'h0000;
  logic        Mem_ready = 1'b0;
  logic        Fetch_req, PC_inc, Src_sel, Byte_op, Wr_en, Flags_wr, Illegal;
  logic [15:0] Instr, Imm;
  logic [3:0]  Src_reg, Dst_reg, Alu_op;
  logic [4:0]  Fsm;

  msp430_double_op_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .Load_en(Load_en), .Mem_data(Mem_data),
    .Mem_ready(Mem_ready), .Fetch_req(Fetch_req), .PC_inc(PC_inc),
    .Instr(Instr), .Imm(Imm), .Src_sel(Src_sel), .Src_reg(Src_reg),
    .Dst_reg(Dst_reg), .Alu_op(Alu_op), .Byte_op(Byte_op), .Wr_en(Wr_en),
    .Flags_wr(Flags_wr), .Fsm(Fsm), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    bit          legal;
    bit          is_imm;
    int          path;
    int          base;
    int          nwords;
    bit          wr;
    bit          fl;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] words[$];
  bit          rdy_q[$];
  int          ready_pct = 100;
  logic [15:0] model_imm = 16'h0000;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the ISA field rules with plain arithmetic.
  function automatic bit model_legal(input int w);
    int op, ad, as_f, src, dst;
    op   = w / 4096;
    src  = (w / 256) % 16;
    ad   = (w / 128) % 2;
    as_f = (w / 16) % 4;
    dst  = w % 16;
    return (op >= 4) && (ad == 0) && ((as_f == 0) || (as_f == 3 && src == 0)) && (dst != 0);
  endfunction

  task automatic issue(input logic [15:0] w, input logic [15:0] immw);
    exp_t e;
    int   x, op;
    x        = int'(w);
    op       = x / 4096;
    e.instr  = w;
    e.legal  = model_legal(x);
    e.is_imm = e.legal && ((x / 16) % 4 == 3);
    words.push_back(w);
    if (e.is_imm) begin
      words.push_back(immw);
      model_imm = immw;
    end
    e.imm    = model_imm;
    e.nwords = e.is_imm ? 2 : 1;
    if (!e.legal) begin
      e.path = (1 * 32 + 2) * 32 + 31;
      e.base = 3;
    end else if (e.is_imm) begin
      e.path = (((1 * 32 + 2) * 32 + 3) * 32 + 4) * 32 + 5;
      e.base = 5;
    end else begin
      e.path = ((1 * 32 + 2) * 32 + 4) * 32 + 5;
      e.base = 4;
    end
    e.wr = e.legal && (op != 9) && (op != 11);
    e.fl = e.legal && (op != 4) && (op != 12) && (op != 13);
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge Clk);
    @(negedge Clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_state(input logic [4:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk); #1;
      if (Fsm == s) break;
    end
    check("reach_state", 32'(Fsm), 32'(s));
  endtask

  // Memory model: serves queued words, optionally stalling.
  initial begin
    bit r;
    forever begin
      @(negedge Clk);
      if (Fetch_req && words.size() != 0) begin
        if (rdy_q.size() != 0) r = rdy_q.pop_front();
        else r = ($urandom_range(99) < ready_pct);
      end else if (Fetch_req) begin
        r = 1'b0;
      end else begin
        r = 1'($urandom_range(1));
      end
      Mem_ready = r;
      Mem_data  = (r && words.size() != 0) ? words[0] : 16'($urandom);
      if (Fetch_req && r) void'(words.pop_front());
    end
  end

  // Monitor: tracks one instruction's trajectory and checks it on WB/ILLEGAL.
  initial begin
    int   path, last, cycles, pcinc, stalls, stray;
    logic sel_exec;
    exp_t e;
    path = 0; last = -1; cycles = 0; pcinc = 0; stalls = 0; stray = 0; sel_exec = 1'b0;
    forever begin
      @(negedge Clk); #1;
      if (!Rst_n || Fsm == 5'd0) begin
        if (PC_inc || Wr_en || Flags_wr || Illegal || Src_sel) stray++;
        path = 0; last = -1; cycles = 0; pcinc = 0; stalls = 0;
      end else begin
        cycles++;
        if (int'(Fsm) != last) begin
          path = path * 32 + int'(Fsm);
          last = int'(Fsm);
        end
        if (PC_inc) pcinc++;
        if (Fetch_req && !Mem_ready) stalls++;
        if (Fsm == 5'd4) sel_exec = Src_sel;
        if ((Wr_en && Fsm != 5'd5) || (Flags_wr && Fsm != 5'd5) ||
            (Illegal && Fsm != 5'd31) || (PC_inc && Fsm != 5'd1 && Fsm != 5'd3)) stray++;
        if (Fsm == 5'd5 || Fsm == 5'd31) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_completion: state %0d with nothing expected", Fsm);
          end else begin
            e = sb.pop_front();
            check("state_path", 32'(path), 32'(e.path));
            check("latency", 32'(cycles), 32'(e.base + stalls));
            check("pc_inc_count", 32'(pcinc), 32'(e.nwords));
            check("instr", 32'(Instr), 32'(e.instr));
            check("imm", 32'(Imm), 32'(e.imm));
            check("src_reg", 32'(Src_reg), 32'((int'(e.instr) / 256) % 16));
            check("dst_reg", 32'(Dst_reg), 32'(int'(e.instr) % 16));
            check("alu_op", 32'(Alu_op), 32'(int'(e.instr) / 4096));
            check("byte_op", 32'(Byte_op), 32'((int'(e.instr) / 64) % 2));
            check("wr_en", 32'(Wr_en), 32'(e.wr));
            check("flags_wr", 32'(Flags_wr), 32'(e.fl));
            check("illegal", 32'(Illegal), 32'(!e.legal));
            if (e.legal) check("src_sel_exec", 32'(sel_exec), 32'(e.is_imm));
            check("stray_strobes", 32'(stray), 32'd0);
          end
          path = 0; last = -1; cycles = 0; pcinc = 0; stalls = 0;
        end
      end
    end
  end

  initial begin
    int          kind;
    logic [15:0] w, iw;

    #1;
    check("rst_fsm", 32'(Fsm), 32'd0);
    check("rst_instr", 32'(Instr), 32'd0);
    check("rst_imm", 32'(Imm), 32'd0);
    check("rst_strobes", 32'({Fetch_req, PC_inc, Src_sel, Byte_op, Wr_en, Flags_wr, Illegal}), 32'd0);
    check("rst_fields", 32'({Src_reg, Dst_reg, Alu_op}), 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    check("idle_without_load_en", 32'(Fsm), 32'd0);

    // Directed instructions with memory always ready.
    issue(16'h5405, 16'h0000);
    issue(16'h4036, 16'h00AA);
    issue(16'h9405, 16'h0000);
    issue(16'hD405, 16'h0000);
    issue(16'h1405, 16'h0000);
    issue(16'h5485, 16'h0000);
    issue(16'h5400, 16'h0000);
    issue(16'h5405, 16'h0000);
    Load_en = 1'b1;
    wait_drain(200);

    // Randomized stream with memory stalls.
    ready_pct = 70;
    for (int n = 0; n < 250; n++) begin
      kind = int'($urandom_range(3));
      iw   = 16'($urandom);
      case (kind)
        0: w = 16'(int'($urandom_range(15, 4)) * 4096 + int'($urandom_range(15)) * 256 +
                   int'($urandom_range(1)) * 64 + int'($urandom_range(15, 1)));
        1: w = 16'(int'($urandom_range(15, 4)) * 4096 + 3 * 16 +
                   int'($urandom_range(1)) * 64 + int'($urandom_range(15, 1)));
        2: begin
          w = 16'($urandom);
          while (model_legal(int'(w))) w = 16'($urandom);
        end
        default: w = 16'($urandom);
      endcase
      issue(w, iw);
    end
    wait_drain(8000);

    // Dropping Load_en in EXEC still completes the write, then idles.
    ready_pct = 100;
    issue(16'h5405, 16'h0000);
    wait_state(5'd4, 100);
    Load_en = 1'b0;
    @(negedge Clk); #1;
    check("drop_load_wb_state", 32'(Fsm), 32'd5);
    check("drop_load_wb_write", 32'(Wr_en), 32'd1);
    @(negedge Clk); #1;
    check("drop_load_then_idle", 32'(Fsm), 32'd0);
    wait_drain(10);

    // Three stall cycles in FETCH and three in IMM: 5 + 6 cycles.
    rdy_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    issue(16'h4036, 16'h00AA);
    Load_en = 1'b1;
    wait_drain(100);

    // Asynchronous reset during EXEC.
    words.push_back(16'h5405);
    wait_state(5'd4, 100);
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_reset_fsm", 32'(Fsm), 32'd0);
    check("async_reset_wr_en", 32'(Wr_en), 32'd0);
    Load_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk); #1;
      check("reset_hold_wr_en", 32'(Wr_en), 32'd0);
    end
    model_imm = 16'h0000;
    check("reset_instr", 32'(Instr), 32'd0);
    check("reset_imm", 32'(Imm), 32'(model_imm));
    Rst_n = 1'b1;
    repeat (3) begin
      @(negedge Clk); #1;
      check("post_reset_no_write", 32'({Wr_en, Fsm}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
